// File: rtl/irq_pkg.sv
// Shared types and constants for the interrupt-acknowledge sequencer.
package irq_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [7:0] IRQ_DEFAULT_VECTOR = 8'hFF;

endpackage

// File: rtl/irq_ack_timer.sv
// Loadable down-counter; expired is high whenever the count sits at zero.
module irq_ack_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expired
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt <= '0;
    else if (load)
      cnt <= load_val;
    else if (cnt != '0)
      cnt <= cnt - 1'b1;
  end

  assign expired = (cnt == '0);

endmodule

// File: rtl/irq_ack_seq.sv
// Interrupt-acknowledge sequencer: timed per-slot INT_ACK strobe and vector capture.
// Optional error counter enabled by defining IRQ_ACK_ERRCNT_EN.
module irq_ack_seq
  import irq_pkg::*;
#(
  parameter int         NUM_IRQ_SLOTS   = 4,
  parameter int         ACK_SETUP_CYC   = 2,
  parameter int         ACK_TIMEOUT_CYC = 16,
  parameter logic [7:0] DEFAULT_VECTOR  = IRQ_DEFAULT_VECTOR
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            ack_cycle,
  input  logic                            ack_chan,
  input  logic [2:0]                      ack_slot,
  input  logic                            ack_slot_valid,
  input  logic [NUM_IRQ_SLOTS-1:0]        slot_vec_valid,
  input  logic [7:0]                      slot_vec_data,
  output logic [NUM_IRQ_SLOTS-1:0][1:0]   slot_int_ack_n,
  output logic                            cpu_wait_n,
  output logic [7:0]                      vec_out,
  output logic                            vec_valid,
  output logic                            ack_err,
  output logic [7:0]                      err_count
);

  // Counter loads are N-1 because the expire flag is seen in the Nth cycle.
  localparam logic [7:0] SETUP_LOAD = 8'(ACK_SETUP_CYC - 1);
  localparam logic [7:0] TMO_LOAD   = 8'(ACK_TIMEOUT_CYC - 1);

  state_t     state, state_nxt;
  logic       ack_prev;
  logic [2:0] slot_q;
  logic       chan_q;
  logic       rise;
  logic [7:0] vv_pad;
  logic       capture;
  logic       tmr_load;
  logic [7:0] tmr_val;
  logic       expired;
  logic       done_cap, done_err;

  logic [7:0][1:0]                    strb_full;
  logic [NUM_IRQ_SLOTS-1:0][1:0]      strb_nxt;
  logic                               wait_n_nxt;
  logic [7:0]                         vec_nxt;
  logic                               vec_valid_nxt;
  logic                               ack_err_nxt;

  assign rise    = ack_cycle & ~ack_prev;
  assign vv_pad  = 8'(slot_vec_valid);
  assign capture = (state == STROBE) && vv_pad[slot_q];

  irq_ack_timer #(.W(8)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .expired  (expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      ack_prev <= 1'b0;
      slot_q   <= '0;
      chan_q   <= 1'b0;
    end else begin
      state    <= state_nxt;
      ack_prev <= ack_cycle;
      if (state == IDLE && rise) begin
        slot_q <= ack_slot;
        chan_q <= ack_chan;
      end
    end
  end

  // Abort takes priority over capture; capture takes priority over timeout.
  always_comb begin
    state_nxt = state;
    tmr_load  = 1'b0;
    tmr_val   = SETUP_LOAD;
    done_cap  = 1'b0;
    done_err  = 1'b0;
    case (state)
      IDLE: begin
        if (rise) begin
          if (ack_slot_valid) begin
            state_nxt = SETUP;
            tmr_load  = 1'b1;
          end else begin
            state_nxt = DONE;
            done_err  = 1'b1;
          end
        end
      end
      SETUP: begin
        if (!ack_cycle)
          state_nxt = IDLE;
        else if (expired) begin
          state_nxt = STROBE;
          tmr_load  = 1'b1;
          tmr_val   = TMO_LOAD;
        end
      end
      STROBE: begin
        if (!ack_cycle)
          state_nxt = IDLE;
        else if (capture) begin
          state_nxt = DONE;
          done_cap  = 1'b1;
        end else if (expired) begin
          state_nxt = DONE;
          done_err  = 1'b1;
        end
      end
      DONE: begin
        if (!ack_cycle)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    wait_n_nxt = !((state_nxt == SETUP) || (state_nxt == STROBE));
    strb_full  = '1;
    if (state_nxt == STROBE)
      strb_full[slot_q][chan_q] = 1'b0;
    strb_nxt = strb_full[NUM_IRQ_SLOTS-1:0];
    vec_nxt  = vec_out;
    if (done_cap)
      vec_nxt = slot_vec_data;
    else if (done_err)
      vec_nxt = DEFAULT_VECTOR;
    vec_valid_nxt = done_cap | done_err;
    ack_err_nxt   = done_err;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_int_ack_n <= '1;
      cpu_wait_n     <= 1'b1;
      vec_out        <= DEFAULT_VECTOR;
      vec_valid      <= 1'b0;
      ack_err        <= 1'b0;
    end else begin
      slot_int_ack_n <= strb_nxt;
      cpu_wait_n     <= wait_n_nxt;
      vec_out        <= vec_nxt;
      vec_valid      <= vec_valid_nxt;
      ack_err        <= ack_err_nxt;
    end
  end

`ifdef IRQ_ACK_ERRCNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      err_count <= 8'h00;
    else if (ack_err_nxt && err_count != 8'hFF)
      err_count <= err_count + 8'h01;
  end
`else
  assign err_count = 8'h00;
`endif

endmodule

// File: tb/tb_irq_ack_seq.sv
// Randomized bench for irq_ack_seq against a cycle-offset reference model.
module tb_irq_ack_seq;

  localparam int N = 4;
  localparam int S = 2;
  localparam int T = 16;

  logic               clk = 1'b0;
  logic               rst;
  logic               ack_cycle, ack_chan, ack_slot_valid;
  logic [2:0]         ack_slot;
  logic [N-1:0]       slot_vec_valid;
  logic [7:0]         slot_vec_data;
  logic [N-1:0][1:0]  slot_int_ack_n;
  logic               cpu_wait_n;
  logic [7:0]         vec_out;
  logic               vec_valid;
  logic               ack_err;
  logic [7:0]         err_count;

  int n_total = 0;
  int n_bad   = 0;

  logic [7:0] m_vec;
  int         m_errs;

  irq_ack_seq dut (
    .clk            (clk),
    .rst            (rst),
    .ack_cycle      (ack_cycle),
    .ack_chan       (ack_chan),
    .ack_slot       (ack_slot),
    .ack_slot_valid (ack_slot_valid),
    .slot_vec_valid (slot_vec_valid),
    .slot_vec_data  (slot_vec_data),
    .slot_int_ack_n (slot_int_ack_n),
    .cpu_wait_n     (cpu_wait_n),
    .vec_out        (vec_out),
    .vec_valid      (vec_valid),
    .ack_err        (ack_err),
    .err_count      (err_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] exp_errcnt();
`ifdef IRQ_ACK_ERRCNT_EN
    return 8'(m_errs);
`else
    return 8'h00;
`endif
  endfunction

  // Cycle 0: ack_cycle first high. r: cycle the addressed slot drives its vector (<=0: never).
  // abort_at: cycle ack_cycle drops if before completion (-1: none). hold: extra high cycles after done.
  task automatic run_txn(input int slot, input int chan, input bit valid, input int r,
                         input logic [7:0] data, input int abort_at, input int hold, input bit noise);
    int e, ee, a, last;
    bit cap, aborted;
    logic [N-1:0][1:0] es;
    logic [N-1:0] vv;
    if (!valid) begin
      e = 1; cap = 1'b0;
    end else if (r >= S + 1 && r <= S + T) begin
      e = r + 1; cap = 1'b1;
    end else begin
      e = S + T + 1; cap = 1'b0;
    end
    if (abort_at >= 1 && abort_at < e) begin
      a = abort_at; aborted = 1'b1; ee = a + 1;
    end else begin
      a = e + hold; aborted = 1'b0; ee = e;
    end
    last = a + 3;
    for (int k = 0; k <= last; k++) begin
      @(negedge clk);
      if (k >= 1) begin
        if (!aborted && k == e) begin
          m_vec = cap ? data : 8'hFF;
          if (!cap && m_errs < 255) m_errs++;
        end
        es = '1;
        if (valid && k >= S + 1 && k < ee) es[slot][chan] = 1'b0;
        chk($sformatf("wait k=%0d", k), 32'(cpu_wait_n), 32'(!(valid && k < ee)));
        chk($sformatf("strobe k=%0d", k), 32'(slot_int_ack_n), 32'(es));
        chk($sformatf("vvalid k=%0d", k), 32'(vec_valid), 32'(!aborted && k == e));
        chk($sformatf("err k=%0d", k), 32'(ack_err), 32'(!aborted && k == e && !cap));
        chk($sformatf("vec k=%0d", k), 32'(vec_out), 32'(m_vec));
        chk($sformatf("errcnt k=%0d", k), 32'(err_count), 32'(exp_errcnt()));
      end
      ack_cycle = (k < a);
      if (k == 0) begin
        ack_slot       = 3'(slot);
        ack_chan       = chan[0];
        ack_slot_valid = valid;
      end else begin
        ack_slot       = 3'($urandom_range(0, 7));
        ack_chan       = 1'($urandom);
        ack_slot_valid = 1'($urandom);
      end
      vv = noise ? N'($urandom) : '0;
      vv[slot] = 1'b0;
      if (r > 0 && k == r) vv[slot] = 1'b1;
      slot_vec_valid = vv;
      slot_vec_data  = (r > 0 && k == r) ? data : 8'($urandom);
    end
  endtask

  initial begin
    logic [N-1:0][1:0] es;
    rst = 1'b1;
    ack_cycle = 0; ack_chan = 0; ack_slot = 0; ack_slot_valid = 0;
    slot_vec_valid = '0; slot_vec_data = '0;
    m_vec = 8'hFF; m_errs = 0;
    repeat (2) @(negedge clk);
    chk("rst strobe", 32'(slot_int_ack_n), 32'(8'hFF));
    chk("rst wait", 32'(cpu_wait_n), 32'd1);
    chk("rst vec", 32'(vec_out), 32'hFF);
    chk("rst vvalid", 32'(vec_valid), 32'd0);
    chk("rst err", 32'(ack_err), 32'd0);
    chk("rst errcnt", 32'(err_count), 32'd0);
    rst = 1'b0;

    run_txn(2, 1, 1'b1, 5, 8'h3C, -1, 3, 1'b0);
    run_txn(0, 0, 1'b0, 0, 8'h00, -1, 0, 1'b0);
    run_txn(0, 0, 1'b1, 0, 8'h00, -1, 2, 1'b0);
    run_txn(1, 1, 1'b1, 0, 8'h00, 4, 0, 1'b0);
    run_txn(3, 0, 1'b1, 6, 8'h5A, -1, 6, 1'b0);
    run_txn(3, 1, 1'b1, 0, 8'h00, -1, 1, 1'b1);
    run_txn(1, 0, 1'b1, S + T, 8'hA5, -1, 1, 1'b0);
    run_txn(2, 0, 1'b1, S + T + 1, 8'h11, -1, 1, 1'b0);
    run_txn(0, 1, 1'b1, S, 8'h22, -1, 0, 1'b1);
    run_txn(0, 1, 1'b1, S + 1, 8'h33, S + 1, 0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      int r, ab;
      r  = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, S + T + 2));
      ab = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, S + T + 1)) : -1;
      run_txn(int'($urandom_range(0, N - 1)), int'($urandom_range(0, 1)),
              ($urandom_range(0, 5) != 0), r, 8'($urandom), ab,
              int'($urandom_range(0, 4)), 1'($urandom));
    end

    // Reset in the middle of STROBE must release everything without waiting for a clock.
    @(negedge clk);
    ack_cycle = 1'b1; ack_slot = 3'd1; ack_chan = 1'b0; ack_slot_valid = 1'b1;
    repeat (5) @(negedge clk);
    es = '1;
    es[1][0] = 1'b0;
    chk("pre-rst strobe", 32'(slot_int_ack_n), 32'(es));
    #2 rst = 1'b1;
    #1;
    chk("async rst strobe", 32'(slot_int_ack_n), 32'(8'hFF));
    chk("async rst wait", 32'(cpu_wait_n), 32'd1);
    chk("async rst vec", 32'(vec_out), 32'hFF);
    chk("async rst vvalid", 32'(vec_valid), 32'd0);
    chk("async rst err", 32'(ack_err), 32'd0);
    chk("async rst errcnt", 32'(err_count), 32'd0);
    ack_cycle = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
